// File: rtl/if_id_queue.sv
// Circular instruction buffer between fetch and decode: accepts up to FETCH_W
// instructions per cycle and presents up to ISSUE_W head entries to decode.
module if_id_queue #(
    parameter int                     DEPTH       = 8,
    parameter int                     FETCH_W     = 2,
    parameter int                     ISSUE_W     = 2,
    parameter int                     EXC_CAUSE_W = 7,
    parameter logic [EXC_CAUSE_W-1:0] EXC_NOP     = '0,
    parameter logic [31:0]            RESET_PC    = 32'h1C00_0000
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               exception_flush,
    input  logic                               branch_flush,
    input  logic [FETCH_W-1:0]                 if_valid,
    input  logic [FETCH_W*32-1:0]              if_pc,
    input  logic [FETCH_W*32-1:0]              if_inst,
    input  logic [FETCH_W*5-1:0]               if_is_exception,
    input  logic [FETCH_W*5*EXC_CAUSE_W-1:0]   if_exception_cause,
    output logic                               if_ready,
    output logic [ISSUE_W-1:0]                 id_valid,
    output logic [ISSUE_W*32-1:0]              id_pc,
    output logic [ISSUE_W*32-1:0]              id_inst,
    output logic [ISSUE_W*5-1:0]               id_is_exception,
    output logic [ISSUE_W*5*EXC_CAUSE_W-1:0]   id_exception_cause,
    input  logic [ISSUE_W-1:0]                 id_accept,
    output logic [$clog2(DEPTH+1)-1:0]         count,
    output logic                               empty,
    output logic                               full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam int CAUSE_W = 5*EXC_CAUSE_W;

    logic [31:0]        pc_mem    [DEPTH];
    logic [31:0]        inst_mem  [DEPTH];
    logic [4:0]         exc_mem   [DEPTH];
    logic [CAUSE_W-1:0] cause_mem [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             flush;
    logic             do_push;
    logic             push_run;
    logic             pop_run;
    logic [CNT_W-1:0] n_push;
    logic [CNT_W-1:0] n_pop;
    logic [CNT_W-1:0] push_amt;
    logic [ISSUE_W-1:0] pop_req;
    logic [PTR_W-1:0] wr_idx [FETCH_W];
    logic [PTR_W-1:0] rd_idx [ISSUE_W];

    assign flush    = exception_flush | branch_flush;
    assign if_ready = (count_q <= CNT_W'(DEPTH - FETCH_W));
    assign do_push  = if_ready & ~flush;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));

    always_comb begin
        for (int j = 0; j < ISSUE_W; j++) begin
            id_valid[j] = (count_q > CNT_W'(j));
            rd_idx[j]   = head_q + PTR_W'(j);
        end
        for (int k = 0; k < FETCH_W; k++) begin
            wr_idx[k] = tail_q + PTR_W'(k);
        end
    end

    assign pop_req = id_accept & id_valid;

    // Only the leading run of ones counts; anything after the first zero is ignored.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        n_push   = '0;
        push_run = 1'b1;
        for (int k = 0; k < FETCH_W; k++) begin
            // NOTE: blocking assignments here because the run flag and count
            // accumulate across iterations; state registers below use <=.
            push_run = push_run & if_valid[k];
            if (push_run) n_push = n_push + CNT_W'(1);
        end
        n_pop   = '0;
        pop_run = 1'b1;
        for (int j = 0; j < ISSUE_W; j++) begin
            pop_run = pop_run & pop_req[j];
            if (pop_run) n_pop = n_pop + CNT_W'(1);
        end
    end

    always_comb begin
        push_amt = do_push ? n_push : '0;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(n_pop);
            tail_d  = tail_q + PTR_W'(push_amt);
            count_d = count_q + push_amt - n_pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: payload RAM has no reset; valid gating on the read side hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push) begin
            for (int k = 0; k < FETCH_W; k++) begin
                if (CNT_W'(k) < n_push) begin
                    pc_mem[wr_idx[k]]    <= if_pc[32*k +: 32];
                    inst_mem[wr_idx[k]]  <= if_inst[32*k +: 32];
                    exc_mem[wr_idx[k]]   <= if_is_exception[5*k +: 5];
                    cause_mem[wr_idx[k]] <= if_exception_cause[CAUSE_W*k +: CAUSE_W];
                end
            end
        end
    end

    // Invalid slots show a fixed bubble so decode never sees stale payload.
    always_comb begin
        id_pc              = '0;
        id_inst            = '0;
        id_is_exception    = '0;
        id_exception_cause = '0;
        for (int j = 0; j < ISSUE_W; j++) begin
            if (id_valid[j]) begin
                id_pc[32*j +: 32]                   = pc_mem[rd_idx[j]];
                id_inst[32*j +: 32]                 = inst_mem[rd_idx[j]];
                id_is_exception[5*j +: 5]           = exc_mem[rd_idx[j]];
                id_exception_cause[CAUSE_W*j +: CAUSE_W] = cause_mem[rd_idx[j]];
            end else begin
                id_pc[32*j +: 32]                   = RESET_PC;
                id_inst[32*j +: 32]                 = '0;
                id_is_exception[5*j +: 5]           = '0;
                id_exception_cause[CAUSE_W*j +: CAUSE_W] = {5{EXC_NOP}};
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: table-driven vectors plus hand sequences
// for fill/full, steady streaming across wrap, and asynchronous reset.
module tb_if_id_queue;

    localparam logic [31:0] B = 32'h1C00_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception_flush, branch_flush;
    logic [1:0]  if_valid;
    logic [63:0] if_pc, if_inst;
    logic [9:0]  if_is_exception;
    logic [69:0] if_exception_cause;
    logic        if_ready;
    logic [1:0]  id_valid;
    logic [63:0] id_pc, id_inst;
    logic [9:0]  id_is_exception;
    logic [69:0] id_exception_cause;
    logic [1:0]  id_accept;
    logic [3:0]  count;
    logic        empty, full;

    int errors = 0;
    int checks = 0;

    if_id_queue dut (
        .clk                (clk),
        .rst                (rst),
        .exception_flush    (exception_flush),
        .branch_flush       (branch_flush),
        .if_valid           (if_valid),
        .if_pc              (if_pc),
        .if_inst            (if_inst),
        .if_is_exception    (if_is_exception),
        .if_exception_cause (if_exception_cause),
        .if_ready           (if_ready),
        .id_valid           (id_valid),
        .id_pc              (id_pc),
        .id_inst            (id_inst),
        .id_is_exception    (id_is_exception),
        .id_exception_cause (id_exception_cause),
        .id_accept          (id_accept),
        .count              (count),
        .empty              (empty),
        .full               (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] pc0;
        logic [1:0]  accept;
        logic        bf;
        logic        ef;
        logic [3:0]  exp_count;
        logic [1:0]  exp_vld;
        logic [31:0] exp_pc0;
        logic [31:0] exp_pc1;
    } vec_t;

    vec_t vecs [15];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h0280_0000 + ((pc - B) << 8);
    endfunction

    function automatic logic [4:0] exc_of(input logic [31:0] pc);
        return pc[6:2];
    endfunction

    function automatic logic [34:0] cause_of(input logic [31:0] pc);
        return {5{pc[8:2]}};
    endfunction

    function automatic logic [1:0] vld_of(input int c);
        return (c >= 2) ? 2'b11 : (c == 1) ? 2'b01 : 2'b00;
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] valid, input logic [31:0] pc0,
                         input logic [1:0] accept, input logic bf, input logic ef);
        logic [31:0] pc1;
        pc1                = pc0 + 32'd4;
        if_valid           = valid;
        if_pc              = {pc1, pc0};
        if_inst            = {inst_of(pc1), inst_of(pc0)};
        if_is_exception    = {exc_of(pc1), exc_of(pc0)};
        if_exception_cause = {cause_of(pc1), cause_of(pc0)};
        id_accept          = accept;
        branch_flush       = bf;
        exception_flush    = ef;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input int exp_count, input logic [1:0] exp_vld,
                               input logic [31:0] pc0, input logic [31:0] pc1);
        logic [31:0] p [2];
        logic [31:0] e_pc;
        p[0] = pc0;
        p[1] = pc1;
        check({tag, ".count"}, 70'(count), 70'(exp_count));
        check({tag, ".id_valid"}, 70'(id_valid), 70'(exp_vld));
        check({tag, ".if_ready"}, 70'(if_ready), 70'(exp_count <= 6));
        check({tag, ".empty"}, 70'(empty), 70'(exp_count == 0));
        check({tag, ".full"}, 70'(full), 70'(exp_count == 8));
        for (int j = 0; j < 2; j++) begin
            e_pc = exp_vld[j] ? p[j] : B;
            check($sformatf("%s.pc%0d", tag, j), 70'(id_pc[32*j +: 32]), 70'(e_pc));
            check($sformatf("%s.inst%0d", tag, j), 70'(id_inst[32*j +: 32]),
                  70'(exp_vld[j] ? inst_of(p[j]) : 32'd0));
            check($sformatf("%s.exc%0d", tag, j), 70'(id_is_exception[5*j +: 5]),
                  70'(exp_vld[j] ? exc_of(p[j]) : 5'd0));
            check($sformatf("%s.cause%0d", tag, j), 70'(id_exception_cause[35*j +: 35]),
                  70'(exp_vld[j] ? cause_of(p[j]) : 35'd0));
        end
    endtask

    initial begin
        int c;
        int h;
        int n;

        vecs[0]  = '{2'b11, B,          2'b00, 1'b0, 1'b0, 4'd2, 2'b11, B,          B + 32'h04};
        vecs[1]  = '{2'b00, B,          2'b01, 1'b0, 1'b0, 4'd1, 2'b01, B + 32'h04, B};
        vecs[2]  = '{2'b10, B + 32'h80, 2'b00, 1'b0, 1'b0, 4'd1, 2'b01, B + 32'h04, B};
        vecs[3]  = '{2'b01, B + 32'h08, 2'b00, 1'b0, 1'b0, 4'd2, 2'b11, B + 32'h04, B + 32'h08};
        vecs[4]  = '{2'b00, B,          2'b10, 1'b0, 1'b0, 4'd2, 2'b11, B + 32'h04, B + 32'h08};
        vecs[5]  = '{2'b00, B,          2'b11, 1'b0, 1'b0, 4'd0, 2'b00, B,          B};
        vecs[6]  = '{2'b01, B,          2'b11, 1'b0, 1'b0, 4'd1, 2'b01, B,          B};
        vecs[7]  = '{2'b11, B + 32'h10, 2'b01, 1'b0, 1'b0, 4'd2, 2'b11, B + 32'h10, B + 32'h14};
        vecs[8]  = '{2'b11, B + 32'h20, 2'b00, 1'b0, 1'b0, 4'd4, 2'b11, B + 32'h10, B + 32'h14};
        vecs[9]  = '{2'b01, B + 32'h30, 2'b00, 1'b0, 1'b0, 4'd5, 2'b11, B + 32'h10, B + 32'h14};
        vecs[10] = '{2'b11, B + 32'h40, 2'b00, 1'b1, 1'b0, 4'd0, 2'b00, B,          B};
        vecs[11] = '{2'b11, B + 32'h50, 2'b00, 1'b0, 1'b0, 4'd2, 2'b11, B + 32'h50, B + 32'h54};
        vecs[12] = '{2'b11, B + 32'h58, 2'b00, 1'b0, 1'b0, 4'd4, 2'b11, B + 32'h50, B + 32'h54};
        vecs[13] = '{2'b01, B + 32'h60, 2'b00, 1'b0, 1'b0, 4'd5, 2'b11, B + 32'h50, B + 32'h54};
        vecs[14] = '{2'b11, B + 32'h70, 2'b11, 1'b0, 1'b1, 4'd0, 2'b00, B,          B};

        rst = 1'b1;
        drive(2'b00, B, 2'b00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_state("reset", 0, 2'b00, B, B);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].valid, vecs[i].pc0, vecs[i].accept, vecs[i].bf, vecs[i].ef);
            step();
            check_state($sformatf("v%0d", i), int'(vecs[i].exp_count), vecs[i].exp_vld,
                        vecs[i].exp_pc0, vecs[i].exp_pc1);
        end

        // Fill to full with no pops; the fifth bundle must be refused.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, B + 32'h100 + 32'(8*i), 2'b00, 1'b0, 1'b0);
            step();
            check_state($sformatf("fill%0d", i), 2*(i+1), 2'b11, B + 32'h100, B + 32'h104);
        end
        drive(2'b11, B + 32'h200, 2'b00, 1'b0, 1'b0);
        step();
        check_state("fill_over", 8, 2'b11, B + 32'h100, B + 32'h104);
        drive(2'b00, B, 2'b01, 1'b0, 1'b0);
        step();
        check_state("pop_to7", 7, 2'b11, B + 32'h104, B + 32'h108);
        drive(2'b11, B + 32'h200, 2'b00, 1'b0, 1'b0);
        step();
        check_state("hold7", 7, 2'b11, B + 32'h104, B + 32'h108);
        c = 7;
        h = 1;
        while (c > 0) begin
            n = (c >= 2) ? 2 : 1;
            drive(2'b00, B, 2'b11, 1'b0, 1'b0);
            step();
            c -= n;
            h += n;
            check_state($sformatf("drain_c%0d", c), c, vld_of(c),
                        B + 32'h100 + 32'(4*h), B + 32'h104 + 32'(4*h));
        end

        // Steady push 2 / pop 2 streams contiguously through several pointer wraps.
        drive(2'b11, B, 2'b00, 1'b0, 1'b0);
        step();
        check_state("stream_pre", 2, 2'b11, B, B + 32'h4);
        for (int i = 0; i < 20; i++) begin
            drive(2'b11, B + 32'(8*(i+1)), 2'b11, 1'b0, 1'b0);
            step();
            check_state($sformatf("stream%0d", i), 2, 2'b11, B + 32'(8*(i+1)), B + 32'(8*(i+1) + 4));
        end
        drive(2'b00, B, 2'b11, 1'b0, 1'b0);
        step();
        check_state("stream_end", 0, 2'b00, B, B);

        // Asynchronous reset between edges with three entries queued.
        drive(2'b11, B + 32'h300, 2'b00, 1'b0, 1'b0);
        step();
        drive(2'b01, B + 32'h308, 2'b00, 1'b0, 1'b0);
        step();
        check_state("pre_rst", 3, 2'b11, B + 32'h300, B + 32'h304);
        drive(2'b00, B, 2'b00, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_state("async_rst", 0, 2'b00, B, B);
        #1 rst = 1'b0;
        drive(2'b11, B + 32'h400, 2'b00, 1'b0, 1'b0);
        step();
        check_state("post_rst", 2, 2'b11, B + 32'h400, B + 32'h404);
        drive(2'b11, B + 32'h408, 2'b01, 1'b0, 1'b0);
        step();
        check_state("post_rst2", 3, 2'b11, B + 32'h404, B + 32'h408);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
